// File: rtl/wb_master_ctrl_if.sv
// wb_master_ctrl_if
//   Groups the command/response handshake and the Wishbone bus of the
//   wb_master_ctrl engine.
//   master modport : the engine side (drives cmd_ready, rsp_*, adr, dat_o,
//                    we, cyc, stb).
//   slave modport  : the environment side (drives cmd_*, rsp_ready, dat_i,
//                    ack, err, rty).
interface wb_master_ctrl_if #(
  parameter int unsigned WB_ADDRESS_W = 8,
  parameter int unsigned WB_WORD_W    = 8
);
  // command port
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_we;
  logic [WB_ADDRESS_W-1:0] cmd_adr;
  logic [WB_WORD_W-1:0]    cmd_dat;
  // response port
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WB_WORD_W-1:0]    rsp_dat;
  logic [1:0]              rsp_status;
  // Wishbone bus
  logic [WB_ADDRESS_W-1:0] adr;
  logic [WB_WORD_W-1:0]    dat_o;
  logic [WB_WORD_W-1:0]    dat_i;
  logic                    we;
  logic                    cyc;
  logic                    stb;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, dat_i, ack, err, rty,
    output cmd_ready, rsp_valid, rsp_dat, rsp_status, adr, dat_o, we, cyc, stb
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, rsp_ready, dat_i, ack, err, rty,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_status, adr, dat_o, we, cyc, stb
  );
endinterface

// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl
//   Wishbone classic-cycle master engine. Accepts one read/write command at
//   a time, runs a single Wishbone cycle for it (with bounded retry on rty
//   and a no-response timeout) and returns data/status on a response port.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : wb_master_ctrl_if.master
//          cmd_valid/cmd_ready/cmd_we/cmd_adr/cmd_dat : command handshake
//          rsp_valid/rsp_ready/rsp_dat/rsp_status     : response handshake
//                 status 00 ok, 01 err, 10 timeout, 11 retry exhausted
//          adr/dat_o/dat_i/we/cyc/stb/ack/err/rty      : Wishbone bus
module wb_master_ctrl #(
  parameter int unsigned WB_ADDRESS_W = 8,
  parameter int unsigned WB_WORD_W    = 8,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned TIMEOUT      = 16
) (
  input logic             clk,
  input logic             rst,
  wb_master_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CYCLE   = 2'd1,
    BACKOFF = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RETRY   = 2'b11;

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_t                  r_state, w_state_nxt;
  logic [WB_ADDRESS_W-1:0] r_adr, w_adr_nxt;
  logic [WB_WORD_W-1:0]    r_dat_o, w_dat_o_nxt;
  logic                    r_we, w_we_nxt;
  logic [WB_WORD_W-1:0]    r_rsp_dat, w_rsp_dat_nxt;
  logic [1:0]              r_rsp_status, w_rsp_status_nxt;
  logic [3:0]              r_retry_cnt, w_retry_cnt_nxt;
  logic [7:0]              r_to_cnt, w_to_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_adr        <= '0;
      r_dat_o      <= '0;
      r_we         <= 1'b0;
      r_rsp_dat    <= '0;
      r_rsp_status <= ST_OK;
      r_retry_cnt  <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_adr        <= w_adr_nxt;
      r_dat_o      <= w_dat_o_nxt;
      r_we         <= w_we_nxt;
      r_rsp_dat    <= w_rsp_dat_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_retry_cnt  <= w_retry_cnt_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_adr_nxt        = r_adr;
    w_dat_o_nxt      = r_dat_o;
    w_we_nxt         = r_we;
    w_rsp_dat_nxt    = r_rsp_dat;
    w_rsp_status_nxt = r_rsp_status;
    w_retry_cnt_nxt  = r_retry_cnt;
    w_to_cnt_nxt     = r_to_cnt;

    unique case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          w_adr_nxt       = bus.cmd_adr;
          w_dat_o_nxt     = bus.cmd_dat;
          w_we_nxt        = bus.cmd_we;
          w_retry_cnt_nxt = '0;
          w_to_cnt_nxt    = '0;
          w_state_nxt     = CYCLE;
        end
      end

      CYCLE: begin
        // A termination in the last allowed cycle beats the timeout.
        if (bus.err) begin
          w_rsp_dat_nxt    = '0;
          w_rsp_status_nxt = ST_ERR;
          w_state_nxt      = RESP;
        end else if (bus.ack) begin
          w_rsp_dat_nxt    = r_we ? '0 : bus.dat_i;
          w_rsp_status_nxt = ST_OK;
          w_state_nxt      = RESP;
        end else if (bus.rty) begin
          if (r_retry_cnt < RETRY_MAX) begin
            w_retry_cnt_nxt = r_retry_cnt + 4'd1;
            w_state_nxt     = BACKOFF;
          end else begin
            w_rsp_dat_nxt    = '0;
            w_rsp_status_nxt = ST_RETRY;
            w_state_nxt      = RESP;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_rsp_dat_nxt    = '0;
          w_rsp_status_nxt = ST_TIMEOUT;
          w_state_nxt      = RESP;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 8'd1;
        end
      end

      BACKOFF: begin
        w_to_cnt_nxt = '0;
        w_state_nxt  = CYCLE;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // cmd_ready is masked while rst is high so no command looks accepted
  // on a reset edge.
  assign bus.cmd_ready  = (r_state == IDLE) && !rst;
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_dat    = r_rsp_dat;
  assign bus.rsp_status = r_rsp_status;
  assign bus.adr        = r_adr;
  assign bus.dat_o      = r_dat_o;
  assign bus.we         = r_we;
  assign bus.cyc        = (r_state == CYCLE);
  assign bus.stb        = (r_state == CYCLE);

endmodule
